// File: rtl/link_tx_pkg.sv
// Shared constants and state encodings for the link transmitter.
package link_tx_pkg;

  localparam logic [7:0] KEYWORD_BYTE  = 8'hFF;
  localparam int         TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    F_SYNC,
    F_IDLE,
    F_SEND_HI,
    F_SEND_LO,
    F_KEEPALIVE
  } framer_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

endpackage

// File: rtl/link_tx_byte_serializer.sv
// 8N1 byte serializer paced by the oversample tick; accepts a new byte in the
// same clk its stop bit ends so frames can run back-to-back.
module link_tx_byte_serializer
  import link_tx_pkg::*;
#(
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tick,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);

  ser_state_e state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          tick_d  = '0;
          sh_d    = din;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = S_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            sh_d   = {1'b0, sh_q[7:1]};
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            byte_done = 1'b1;
            tick_d    = '0;
            // Chained load skips IDLE so the next start bit follows directly.
            if (load) begin
              state_d = S_START;
              sh_d    = din;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = sh_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: rtl/link_tx.sv
// Link transmitter: KEYWORD sync bursts while the link is down, two-byte word
// framing while it is up, and keep-alive KEYWORDs after a long idle.
module link_tx
  import link_tx_pkg::*;
#(
  parameter logic [7:0] KEYWORD    = KEYWORD_BYTE,
  parameter int         SB_TICK    = 16,
  parameter int         IDLE_TICKS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_tick,
  input  logic        link_up,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        byte_done,
  output logic        busy
);

  localparam logic [11:0] IDLE_LAST = 12'(IDLE_TICKS - 1);

  framer_state_e st_q, st_d;
  logic [11:0] idle_q, idle_d;
  logic [7:0]  lo_q, lo_d;
  logic        ser_load;
  logic [7:0]  ser_din;
  logic        ser_free;

  link_tx_byte_serializer #(.SB_TICK(SB_TICK)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tick    (s_tick),
    .load      (ser_load),
    .din       (ser_din),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= F_SYNC;
      idle_q <= '0;
      lo_q   <= '0;
    end else begin
      st_q   <= st_d;
      idle_q <= idle_d;
      lo_q   <= lo_d;
    end
  end

  assign ser_free = ~busy | byte_done;

  // The idle counter only runs in F_IDLE; every other state holds it at zero.
  always_comb begin
    st_d       = st_q;
    idle_d     = '0;
    lo_d       = lo_q;
    ser_load   = 1'b0;
    ser_din    = KEYWORD;
    word_ready = 1'b0;
    case (st_q)
      F_SYNC: begin
        if (byte_done && link_up) st_d     = F_IDLE;
        else                      ser_load = ser_free;
      end
      F_IDLE: begin
        word_ready = link_up & ~busy;
        idle_d     = idle_q;
        if (!link_up) begin
          st_d     = F_SYNC;
          ser_load = ser_free;
        end else if (word_valid && word_ready) begin
          ser_load = 1'b1;
          ser_din  = word_in[15:8];
          lo_d     = word_in[7:0];
          idle_d   = '0;
          st_d     = F_SEND_HI;
        end else if (s_tick) begin
          if (idle_q == IDLE_LAST) begin
            ser_load = 1'b1;
            idle_d   = '0;
            st_d     = F_KEEPALIVE;
          end else begin
            idle_d = idle_q + 12'd1;
          end
        end
      end
      F_SEND_HI: begin
        if (byte_done) begin
          ser_load = 1'b1;
          ser_din  = lo_q;
          st_d     = F_SEND_LO;
        end
      end
      F_SEND_LO, F_KEEPALIVE: begin
        if (byte_done) begin
          if (link_up) begin
            st_d = F_IDLE;
          end else begin
            st_d     = F_SYNC;
            ser_load = 1'b1;
          end
        end
      end
      default: st_d = F_SYNC;
    endcase
  end

endmodule

// File: tb/tb_link_tx.sv
// Randomized bench for link_tx: frame-level reference model checked every clk.
module tb_link_tx;

  localparam int FRAME = 16 + 8 * 16 + 16;
  localparam logic [7:0] KW = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n, s_tick, link_up, word_valid;
  logic [15:0] word_in;
  logic        word_ready, tx, byte_done, busy;

  int vectors = 0;
  int miscompares = 0;

  link_tx dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .link_up(link_up),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .tx(tx), .byte_done(byte_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Tick generator: fixed period or random 1..3 clk spacing, plus a force.
  bit tick_fixed = 1'b1;
  int tick_period = 35;
  bit force_tick = 1'b0;
  int gap_cnt = 0;
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (force_tick) s_tick = 1'b1;
      else if (gap_cnt == 0) begin
        s_tick  = 1'b1;
        gap_cnt = tick_fixed ? tick_period - 1 : int'($urandom_range(0, 2));
      end else begin
        s_tick = 1'b0;
        gap_cnt--;
      end
    end
  end

  // Reference model: a frame is a tick index 0..FRAME-1 from which the line
  // level follows directly; the framer rules decide which byte comes next.
  typedef enum {M_SYNC, M_IDLE, M_HI, M_LO, M_KA} mmode_e;
  mmode_e     m_mode = M_SYNC;
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_lo = 8'h00;
  int         m_cnt = 0;
  int         m_acc = 0;
  int         tick_no = 0;
  int         m_entry = 0;
  int         dut_done_cnt = 0;
  logic [7:0] m_log[$];
  int         m_ka[$];

  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    if (m_t < 16) return 1'b0;
    if (m_t < 144) return m_byte[3'((m_t - 16) / 16)];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit         e_done, e_ready, ld;
    logic [7:0] lb;
    if (!rst_n) begin
      m_mode = M_SYNC; m_act = 1'b0; m_t = 0; m_cnt = 0;
      check1("rst_tx", tx, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_byte_done", byte_done, 1'b0);
      check1("rst_word_ready", word_ready, 1'b0);
    end else begin
      e_done  = m_act && s_tick && (m_t == FRAME - 1);
      e_ready = (m_mode == M_IDLE) && link_up && !m_act;
      check1("tx", tx, exp_tx());
      check1("busy", busy, m_act);
      check1("byte_done", byte_done, e_done);
      check1("word_ready", word_ready, e_ready);
      if (byte_done) dut_done_cnt++;
      if (s_tick) tick_no++;
      ld = 1'b0;
      lb = KW;
      case (m_mode)
        M_SYNC: begin
          if (e_done && link_up) begin
            m_mode = M_IDLE; m_cnt = 0; m_entry = tick_no;
          end else if (!m_act || e_done) ld = 1'b1;
        end
        M_IDLE: begin
          if (!link_up) begin
            m_mode = M_SYNC; ld = 1'b1;
          end else if (e_ready && word_valid) begin
            ld = 1'b1; lb = word_in[15:8]; m_lo = word_in[7:0];
            m_mode = M_HI; m_acc++;
          end else if (s_tick) begin
            if (m_cnt == 2047) begin
              ld = 1'b1; m_mode = M_KA; m_ka.push_back(tick_no);
            end else m_cnt++;
          end
        end
        M_HI: if (e_done) begin ld = 1'b1; lb = m_lo; m_mode = M_LO; end
        default: begin
          if (e_done) begin
            if (link_up) begin
              m_mode = M_IDLE; m_cnt = 0; m_entry = tick_no;
            end else begin
              m_mode = M_SYNC; ld = 1'b1;
            end
          end
        end
      endcase
      if (m_act && s_tick) m_t++;
      if (e_done) m_act = 1'b0;
      if (ld) begin
        m_act = 1'b1; m_t = 0; m_byte = lb; m_log.push_back(lb);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(m_mode == M_IDLE && !m_act) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) timeout(nm);
  endtask

  task automatic send_word(input logic [15:0] w);
    int a0 = m_acc;
    int n = 0;
    @(posedge clk);
    #1 word_in = w; word_valid = 1'b1;
    while (m_acc == a0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) timeout("word_accept");
    #1 word_valid = 1'b0;
    @(negedge clk);
    check1("tx_fall_after_accept", tx, 1'b0);
  endtask

  initial begin
    int n0, k0, e0, a0, n;
    logic [15:0] w;
    rst_n = 1'b0; link_up = 1'b0; word_valid = 1'b0; word_in = '0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sync burst at the slow 35-clk tick: exactly one frame done by ~200 ticks.
    repeat (7000) @(posedge clk);
    check_int("sync_done_count", dut_done_cnt, 1);
    check8("sync_first_byte", m_log[0], 8'hFF);

    tick_fixed = 1'b0;
    repeat ($urandom_range(20, 200)) @(posedge clk);
    #1 link_up = 1'b1;
    n = 0;
    while (m_mode != M_IDLE && n < 2000) begin @(posedge clk); n++; end
    if (n >= 2000) timeout("link_up_to_idle");
    @(negedge clk);
    check1("ready_after_sync", word_ready, 1'b1);

    n0 = m_log.size();
    send_word(16'h12A5);
    wait_idle("word_12a5");
    check8("hi_byte_12", m_log[n0], 8'h12);
    check8("lo_byte_a5", m_log[n0 + 1], 8'hA5);
    check_int("bytes_for_word", m_log.size() - n0, 2);

    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      if (w[15:8] == 8'hFF) w[15:8] = 8'h7E;
      if (i == 3) w[7:0] = 8'hFF;
      repeat ($urandom_range(0, 30)) @(posedge clk);
      send_word(w);
    end
    wait_idle("random_words");

    // Accept lands on the very tick that would trigger the keep-alive.
    n = 0;
    while (!(m_mode == M_IDLE && m_cnt == 2047) && n < 10000) begin @(posedge clk); n++; end
    if (n >= 10000) timeout("idle_count_reach");
    force_tick = 1'b1;
    a0 = m_acc;
    #1 word_in = 16'h4242; word_valid = 1'b1;
    @(posedge clk);
    force_tick = 1'b0;
    #1 word_valid = 1'b0;
    check_int("accept_beats_timeout", m_acc - a0, 1);
    check8("accept_hi_byte", m_log[m_log.size() - 1], 8'h42);
    wait_idle("tie_word");

    e0 = m_entry;
    k0 = m_ka.size();
    n = 0;
    while (m_ka.size() < k0 + 3 && n < 30000) begin @(posedge clk); n++; end
    if (n >= 30000) timeout("keepalive");
    else begin
      check_int("ka_first_delay", m_ka[k0] - e0, 2048);
      check_int("ka_period_1", m_ka[k0 + 1] - m_ka[k0], 2048 + FRAME);
      check_int("ka_period_2", m_ka[k0 + 2] - m_ka[k0 + 1], 2048 + FRAME);
    end
    wait_idle("after_keepalive");

    // Link drops during the high byte: low byte still goes, then sync.
    n0 = m_log.size();
    send_word(16'h3C0F);
    repeat (40) @(posedge clk);
    #1 link_up = 1'b0; word_in = 16'h7777; word_valid = 1'b1;
    a0 = m_acc;
    n = 0;
    while (m_log.size() < n0 + 4 && n < 3000) begin @(posedge clk); n++; end
    if (n >= 3000) timeout("link_drop");
    check8("drop_hi", m_log[n0], 8'h3C);
    check8("drop_lo", m_log[n0 + 1], 8'h0F);
    check8("drop_sync1", m_log[n0 + 2], 8'hFF);
    check8("drop_sync2", m_log[n0 + 3], 8'hFF);
    check_int("no_accept_link_down", m_acc - a0, 0);
    #1 word_valid = 1'b0;

    // Async reset during a zero data bit.
    link_up = 1'b1;
    wait_idle("relink");
    send_word(16'h5500);
    n = 0;
    while (!(m_act && m_t >= 16 && m_t < 144 && exp_tx() == 1'b0) && n < 2000) begin
      @(posedge clk); n++;
    end
    if (n >= 2000) timeout("find_zero_bit");
    #2 check1("tx_low_before_rst", tx, 1'b0);
    #1 rst_n = 1'b0;
    #1 check1("tx_async_rst", tx, 1'b1);
    check1("busy_async_rst", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check1("tx_after_release", tx, 1'b1);
    check1("ready_after_release", word_ready, 1'b0);
    repeat (1000) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
